// File: rtl/gcd_pkg.sv
// Shared definitions for the sequential GCD engine (gcd_seq).
// Optional iteration counter is enabled with GCD_ITER_COUNT_EN.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_seq_if.sv
// Operand/result handshake bundle for gcd_seq.
// iter_cnt exists only when GCD_ITER_COUNT_EN is defined.
interface gcd_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic             coprime;
  logic             busy;
`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_cnt;

  modport master (output in_valid, A, B, out_ready,
                  input  in_ready, out_valid, gcd_out, coprime, busy, iter_cnt);
  modport slave  (input  in_valid, A, B, out_ready,
                  output in_ready, out_valid, gcd_out, coprime, busy, iter_cnt);
`else
  modport master (output in_valid, A, B, out_ready,
                  input  in_ready, out_valid, gcd_out, coprime, busy);
  modport slave  (input  in_valid, A, B, out_ready,
                  output in_ready, out_valid, gcd_out, coprime, busy);
`endif
endinterface

// File: rtl/gcd_step.sv
// One subtractive-Euclid step: compares a/b and produces the next operand pair.
module gcd_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next
);

  // Always larger-minus-smaller, so neither operand can wrap.
  always_comb begin
    eq     = (a == b);
    gt     = (a > b);
    lt     = (a < b);
    a_next = a;
    b_next = b;
    if (gt) begin
      a_next = a - b;
    end else if (lt) begin
      b_next = b - a;
    end
  end

endmodule

// File: rtl/gcd_seq.sv
// Sequential GCD engine, one subtraction per clock, valid/ready on both sides.
// Define GCD_ITER_COUNT_EN to add the saturating iter_cnt step counter.
module gcd_seq
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  gcd_seq_if.slave   io
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             busy;
  logic [WIDTH-1:0] gcd_out;
  logic             coprime;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             accept;
  logic             zero_op;
  logic [WIDTH-1:0] zero_res;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .b      (b),
    .eq     (eq),
    .gt     (gt),
    .lt     (lt),
    .a_next (a_next),
    .b_next (b_next)
  );

  // In DONE a new pair may be taken on the same edge the result is retired.
  assign io.in_ready = (state == ST_IDLE) | ((state == ST_DONE) & io.out_ready);
  assign accept      = io.in_valid & io.in_ready;
  assign zero_op     = (io.A == '0) | (io.B == '0);
  assign zero_res    = io.A | io.B;

  assign io.out_valid = out_valid;
  assign io.busy      = busy;
  assign io.gcd_out   = gcd_out;
  assign io.coprime   = coprime;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      gcd_out   <= '0;
      coprime   <= 1'b0;
    end else begin
      unique case (state)
        ST_CALC: begin
          if (eq) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            gcd_out   <= a;
            coprime   <= (a == ONE);
          end else begin
            if (gt) a <= a_next;
            if (lt) b <= b_next;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            a <= io.A;
            b <= io.B;
            if (zero_op) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              gcd_out   <= zero_res;
              coprime   <= (zero_res == ONE);
            end else begin
              state     <= ST_CALC;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end
          end else if ((state == ST_DONE) && io.out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_cnt;

  assign io.iter_cnt = iter_cnt;

  // Cleared on every accept, saturating count of subtractions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt <= '0;
    end else if (accept) begin
      iter_cnt <= '0;
    end else if ((state == ST_CALC) && !eq && (iter_cnt != '1)) begin
      iter_cnt <= iter_cnt + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_seq.sv
// Self-checking bench for gcd_seq (8- and 16-bit instances), scoreboard of expected results.
// Build with or without GCD_ITER_COUNT_EN; iter_cnt is checked only when defined.
module tb_gcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  gcd_seq_if #(.WIDTH(8))  io8 ();
  gcd_seq_if #(.WIDTH(16)) io16 ();

  gcd_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .io(io8.slave));
  gcd_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .io(io16.slave));

  typedef struct {
    int g;
    int k;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Division-based Euclid; subtraction count = sum of quotients - 1.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int x, y, t;
    if (a == 0 || b == 0) begin
      e.g = a | b;
      e.k = 0;
    end else begin
      x = a; y = b; e.k = 0;
      while (y != 0) begin
        e.k += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      e.g = x;
      e.k = e.k - 1;
    end
    return e;
  endfunction

  // A result is retired on the next rising edge whenever valid&ready is seen here.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst && io8.out_valid && io8.out_ready) begin
      if (q8.size() == 0) check("dut8_spurious_result", 1, 0);
      else begin
        e = q8.pop_front();
        check("dut8_gcd", 32'(io8.gcd_out), e.g);
        check("dut8_coprime", 32'(io8.coprime), 32'(e.g == 1));
`ifdef GCD_ITER_COUNT_EN
        check("dut8_iter", 32'(io8.iter_cnt), e.k);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst && io16.out_valid && io16.out_ready) begin
      if (q16.size() == 0) check("dut16_spurious_result", 1, 0);
      else begin
        e = q16.pop_front();
        check("dut16_gcd", 32'(io16.gcd_out), e.g);
        check("dut16_coprime", 32'(io16.coprime), 32'(e.g == 1));
`ifdef GCD_ITER_COUNT_EN
        check("dut16_iter", 32'(io16.iter_cnt), e.k);
`endif
      end
    end
  end

  // Latency counts the accept edge as edge 1: zero operand -> 1, otherwise k+2.
  task automatic op8(input int a, input int b, input bit lat_chk);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    io8.A = 8'(a); io8.B = 8'(b); io8.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!io8.in_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("dut8_accept_timeout", 1, 0);
    @(posedge clk);
    e = model(a, b);
    q8.push_back(e);
    #1 io8.in_valid = 1'b0;
    if (lat_chk) begin
      n = 1;
      @(negedge clk);
      while (!io8.out_valid && n < 2000) begin @(negedge clk); n++; end
      check("dut8_latency", n, (a == 0 || b == 0) ? 1 : e.k + 2);
    end
  endtask

  task automatic op16(input int a, input int b);
    int n;
    @(posedge clk); #1;
    io16.A = 16'(a); io16.B = 16'(b); io16.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!io16.in_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("dut16_accept_timeout", 1, 0);
    @(posedge clk);
    q16.push_back(model(a, b));
    #1 io16.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check(tag, 1, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    io8.in_valid  = 1'b0; io8.A  = '0; io8.B  = '0; io8.out_ready  = 1'b1;
    io16.in_valid = 1'b0; io16.A = '0; io16.B = '0; io16.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(io8.in_ready), 1);
    check("rst_out_valid", 32'(io8.out_valid), 0);
    check("rst_busy", 32'(io8.busy), 0);
    check("rst_gcd_out", 32'(io8.gcd_out), 0);
    check("rst_coprime", 32'(io8.coprime), 0);
`ifdef GCD_ITER_COUNT_EN
    check("rst_iter", 32'(io8.iter_cnt), 0);
`endif
    @(posedge clk); #1 rst = 1'b1;

    op8(12, 18, 1);
    op8(17, 60, 1);
    op8(255, 1, 1);
    op8(0, 9, 1);
    op8(0, 0, 1);
    op8(7, 7, 1);
    drain("drain1_timeout");

    // Back-pressure: result held, new pair refused until the consumer takes it.
    @(posedge clk); #1 io8.out_ready = 1'b0;
    op8(12, 18, 1);
    @(posedge clk); #1;
    io8.A = 8'(17); io8.B = 8'(60); io8.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(io8.out_valid), 1);
      check("hold_gcd_out", 32'(io8.gcd_out), 6);
      check("hold_in_ready", 32'(io8.in_ready), 0);
    end
    @(posedge clk); #1 io8.out_ready = 1'b1;
    @(posedge clk);
    q8.push_back(model(17, 60));
    #1 io8.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_out_valid_low", 32'(io8.out_valid), 0);
    check("b2b_busy", 32'(io8.busy), 1);
    drain("drain2_timeout");

    // Reset in the middle of a long calculation.
    op8(200, 3, 0);
    @(negedge clk);
    check("calc_busy", 32'(io8.busy), 1);
    check("calc_in_ready", 32'(io8.in_ready), 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(io8.out_valid), 0);
    check("midrst_busy", 32'(io8.busy), 0);
    check("midrst_gcd_out", 32'(io8.gcd_out), 0);
    check("midrst_coprime", 32'(io8.coprime), 0);
    check("midrst_in_ready", 32'(io8.in_ready), 1);
`ifdef GCD_ITER_COUNT_EN
    check("midrst_iter", 32'(io8.iter_cnt), 0);
`endif
    q8.delete();
    @(posedge clk); #1 rst = 1'b1;
    seen = 1'b0;
    repeat (80) begin @(negedge clk); seen |= io8.out_valid; end
    check("midrst_no_result", 32'(seen), 0);
    op8(21, 14, 1);
    drain("drain3_timeout");

    op16(65535, 65535);
    op16(48000, 18000);
    op16(0, 40000);
    drain("drain4_timeout");

    check("q8_empty", q8.size(), 0);
    check("q16_empty", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
